// File: rtl/logic_pkg.sv
// Shared types and constants for the logic gate datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: operand-stage occupancy state, default widths and the
// op tag encodings understood by the 2-input gate units.
package logic_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int OPW_DEF   = 2;

   // Encoding doubles as the entry count (0/1/2).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam logic [1:0] OP_AND = 2'd0;
   localparam logic [1:0] OP_OR  = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;
   localparam logic [1:0] OP_NOR = 2'd3;

endpackage

// File: rtl/logic_operand_stage_operand_reg.sv
// Enable register with synchronous clear, holds one operand pair + tag.
// Latency: 1 cycle from en to q.
// Backpressure: none; q holds whenever en is low.
//
// Ports: clk, clr (sync, active-high, wins over en), en, d[W-1:0], q[W-1:0].
module operand_reg #(
   parameter int W = 18
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/logic_operand_stage.sv
// Two-entry skid buffer presenting registered X/Y/OP to the logic gate units.
// Latency: 1 cycle accept-to-OUT_VALID when empty; 1 pair/cycle streaming.
// Backpressure: IN_READY drops only when both entries are held; it is a
//               pure function of registered state (no OUT_READY path).
//
// Ports: CLK, RST (sync, active-high); IN_VALID/IN_READY/IN_X/IN_Y/IN_OP
// from decode; OUT_VALID/OUT_READY/X/Y/OP to the gate unit.
// Build option LOGIC_OPERAND_STAGE_OCC_EN adds OCC[1:0] (entry count) and
// OVF_ERR (sticky: IN_VALID held 16 consecutive cycles while full).
module logic_operand_stage
   import logic_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN_X,
   input  logic [WIDTH-1:0] IN_Y,
   input  logic [OPW-1:0]   IN_OP,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] X,
   output logic [WIDTH-1:0] Y,
   output logic [OPW-1:0]   OP
`ifdef LOGIC_OPERAND_STAGE_OCC_EN
   ,
   output logic [1:0]       OCC,
   output logic             OVF_ERR
`endif
);

   localparam int PW = 2 * WIDTH + OPW;

   state_t        state_q;
   state_t        state_d;
   logic          accept;
   logic          consume;
   logic          head_en;
   logic          skid_en;
   logic [PW-1:0] in_pair;
   logic [PW-1:0] head_d;
   logic [PW-1:0] head_q;
   logic [PW-1:0] skid_q;

   assign IN_READY  = (state_q != FULL) && !RST;
   assign OUT_VALID = (state_q != EMPTY);
   assign accept    = IN_VALID && IN_READY;
   assign consume   = OUT_VALID && OUT_READY;
   assign in_pair   = {IN_X, IN_Y, IN_OP};

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and register load enables
   always_comb begin
      state_d = state_q;
      head_en = 1'b0;
      skid_en = 1'b0;
      head_d  = in_pair;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               head_en = 1'b1;
            end
         end
         ONE: begin
            if (accept && consume) begin
               head_en = 1'b1;           // pass-through, stay ONE
            end else if (accept) begin
               state_d = FULL;
               skid_en = 1'b1;
            end else if (consume) begin
               state_d = EMPTY;          // head keeps its stale contents
            end
         end
         FULL: begin
            // accept cannot happen here: IN_READY is low
            if (consume) begin
               state_d = ONE;
               head_en = 1'b1;
               head_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   operand_reg #(.W(PW)) u_head (
      .clk (CLK),
      .clr (RST),
      .en  (head_en),
      .d   (head_d),
      .q   (head_q)
   );

   operand_reg #(.W(PW)) u_skid (
      .clk (CLK),
      .clr (RST),
      .en  (skid_en),
      .d   (in_pair),
      .q   (skid_q)
   );

   assign X  = head_q[PW-1 -: WIDTH];
   assign Y  = head_q[OPW +: WIDTH];
   assign OP = head_q[OPW-1:0];

`ifdef LOGIC_OPERAND_STAGE_OCC_EN
   logic [3:0] stall_cnt;

   assign OCC = state_q;

   // Counts consecutive cycles of IN_VALID while full; the 16th sets the flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt <= '0;
         OVF_ERR   <= 1'b0;
      end else if (IN_VALID && (state_q == FULL)) begin
         if (stall_cnt == 4'd15) begin
            OVF_ERR <= 1'b1;
         end else begin
            stall_cnt <= stall_cnt + 4'd1;
         end
      end else begin
         stall_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_logic_operand_stage.sv
// Directed self-checking bench for logic_operand_stage.
// Latency: checks 1-cycle accept-to-output and 1 pair/cycle streaming.
// Backpressure: exercises skid fill, hold under OUT_READY=0 and drain.
module tb_logic_operand_stage;
   import logic_pkg::*;

   logic       CLK;
   logic       RST;
   logic       IN_VALID;
   logic       IN_READY;
   logic [7:0] IN_X;
   logic [7:0] IN_Y;
   logic [1:0] IN_OP;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic [7:0] X;
   logic [7:0] Y;
   logic [1:0] OP;
`ifdef LOGIC_OPERAND_STAGE_OCC_EN
   logic [1:0] OCC;
   logic       OVF_ERR;
`endif

   int npass;
   int ntotal;

   logic_operand_stage #(.WIDTH(8), .OPW(2)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .IN_X      (IN_X),
      .IN_Y      (IN_Y),
      .IN_OP     (IN_OP),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .X         (X),
      .Y         (Y),
      .OP        (OP)
`ifdef LOGIC_OPERAND_STAGE_OCC_EN
      ,
      .OCC       (OCC),
      .OVF_ERR   (OVF_ERR)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model of the downstream gate unit.
   function automatic logic [7:0] gate(input logic [1:0] op,
                                       input logic [7:0] a,
                                       input logic [7:0] b);
      case (op)
         OP_AND:  gate = a & b;
         OP_OR:   gate = a | b;
         OP_XOR:  gate = a ^ b;
         default: gate = ~(a | b);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] x,
                        input logic [7:0] y, input logic [1:0] op);
      IN_VALID = v;
      IN_X     = x;
      IN_Y     = y;
      IN_OP    = op;
   endtask

   initial begin
      npass  = 0;
      ntotal = 0;

      // Reset with a valid pair offered: nothing may be accepted.
      RST       = 1'b1;
      OUT_READY = 1'b0;
      drive(1'b1, 8'hFF, 8'hFF, 2'd3);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst_out_valid", OUT_VALID, 0);
         check("rst_x", X, 0);
         check("rst_in_ready", IN_READY, 0);
      end
      RST = 1'b0;
      drive(1'b0, 8'h00, 8'h00, 2'd0);
      #1;
      check("post_rst_in_ready", IN_READY, 1);
      check("post_rst_out_valid", OUT_VALID, 0);

      // Single transfer into the OR gate.
      OUT_READY = 1'b1;
      drive(1'b1, 8'h0F, 8'hF0, OP_OR);
      tick();
      drive(1'b0, 8'h00, 8'h00, 2'd0);
      check("single_valid", OUT_VALID, 1);
      check("single_x", X, 32'h0F);
      check("single_y", Y, 32'hF0);
      check("single_op", OP, 1);
      check("single_or", gate(OP, X, Y), 32'hFF);
      tick();
      check("single_drained", OUT_VALID, 0);

      // Back-pressure: fill head and skid.
      OUT_READY = 1'b0;
      drive(1'b1, 8'h01, 8'h02, OP_AND);
      tick();
      check("bp_a_x", X, 32'h01);
      drive(1'b1, 8'h03, 8'h04, OP_XOR);
      tick();
      check("bp_full_in_ready", IN_READY, 0);
`ifdef LOGIC_OPERAND_STAGE_OCC_EN
      check("bp_occ_full", OCC, 2);
`endif
      drive(1'b1, 8'h09, 8'h0A, OP_NOR);   // C waits
      tick();
      check("bp_hold_x", X, 32'h01);
      check("bp_hold_y", Y, 32'h02);
      check("bp_hold_in_ready", IN_READY, 0);
      OUT_READY = 1'b1;
      tick();                               // A consumed, B to head
      check("bp_b_x", X, 32'h03);
      check("bp_b_y", Y, 32'h04);
      check("bp_b_op", OP, 2);
      check("bp_one_in_ready", IN_READY, 1);
      tick();                               // B consumed, C accepted
      drive(1'b0, 8'h00, 8'h00, 2'd0);
      check("bp_c_x", X, 32'h09);
      check("bp_c_op", OP, 3);
      tick();
      check("bp_drained", OUT_VALID, 0);

      // Streaming, one pair per cycle.
      OUT_READY = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 8'(i), ~8'(i), OP_XOR);
         tick();
         check("stream_in_ready", IN_READY, 1);
         check("stream_valid", OUT_VALID, 1);
         check("stream_x", X, i);
         check("stream_y", Y, {24'd0, ~8'(i)});
      end
      drive(1'b0, 8'h00, 8'h00, 2'd0);
      tick();
      check("stream_drained", OUT_VALID, 0);

      // Simultaneous accept and consume while ONE.
      OUT_READY = 1'b0;
      drive(1'b1, 8'h05, 8'h06, OP_AND);
      tick();
      check("sim_head_x", X, 32'h05);
      OUT_READY = 1'b1;
      drive(1'b1, 8'h07, 8'h08, OP_OR);
      tick();
      drive(1'b0, 8'h00, 8'h00, 2'd0);
      check("sim_x", X, 32'h07);
      check("sim_y", Y, 32'h08);
      check("sim_in_ready", IN_READY, 1);
      check("sim_valid", OUT_VALID, 1);
      tick();
      check("sim_drained", OUT_VALID, 0);

      // Reset while FULL discards both entries.
      OUT_READY = 1'b0;
      drive(1'b1, 8'h11, 8'h12, OP_AND);
      tick();
      drive(1'b1, 8'h13, 8'h14, OP_AND);
      tick();
      check("rf_full", IN_READY, 0);
      drive(1'b0, 8'h00, 8'h00, 2'd0);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("rf_out_valid", OUT_VALID, 0);
      check("rf_x", X, 0);
`ifdef LOGIC_OPERAND_STAGE_OCC_EN
      check("rf_occ", OCC, 0);
      check("rf_ovf", OVF_ERR, 0);
`endif
      OUT_READY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rf_no_ghost", OUT_VALID, 0);
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
